// File: rtl/inst_encoder_loader.sv
// RV32I instruction encoder and instruction-memory loader: packs symbolic
// requests (add/sub/and/or/lw/sw/beq) into words written to consecutive addresses.
module inst_encoder_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [12:0]       req_imm,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   inst_count,
    output logic              load_done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_BEQ = 3'd6;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_OP    = 2'd1;
    localparam logic [1:0] ERR_IMM   = 2'd2;
    localparam logic [1:0] ERR_OVFL  = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENC   = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [12:0] imm_q;
    logic        last_q;

    logic [31:0] enc_word;
    logic [1:0]  enc_code;
    logic [6:0]  funct7;
    logic [2:0]  funct3;

    // Encode the captured request; unused fields of each format are ignored.
    always_comb begin
        enc_word = 32'h0;
        funct7   = 7'b0000000;
        funct3   = 3'b000;
        unique case (op_q)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                funct7 = (op_q == OP_SUB) ? 7'b0100000 : 7'b0000000;
                case (op_q)
                    OP_AND:  funct3 = 3'b111;
                    OP_OR:   funct3 = 3'b110;
                    default: funct3 = 3'b000;
                endcase
                enc_word = {funct7, rs2_q, rs1_q, funct3, rd_q, 7'b0110011};
            end
            OP_LW:   enc_word = {imm_q[11:0], rs1_q, 3'b010, rd_q, 7'b0000011};
            OP_SW:   enc_word = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
            OP_BEQ:  enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000,
                                 imm_q[4:1], imm_q[11], 7'b1100011};
            default: enc_word = 32'h0;
        endcase
    end

    // Error checks in priority order: bad op, immediate range, overflow.
    always_comb begin
        enc_code = ERR_NONE;
        if (op_q == 3'd7) begin
            enc_code = ERR_OP;
        end else if ((op_q == OP_LW || op_q == OP_SW) && (imm_q[12] != imm_q[11])) begin
            enc_code = ERR_IMM;
        end else if (op_q == OP_BEQ && imm_q[0]) begin
            enc_code = ERR_IMM;
        end else if (inst_count == CNT_W'(DEPTH)) begin
            enc_code = ERR_OVFL;
        end
    end

    // Control FSM with all outputs registered; reset aborts any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            op_q       <= 3'd0;
            rd_q       <= 5'd0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            imm_q      <= 13'd0;
            last_q     <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0;
            inst_count <= '0;
            load_done  <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        rd_q      <= req_rd;
                        rs1_q     <= req_rs1;
                        rs2_q     <= req_rs2;
                        imm_q     <= req_imm;
                        last_q    <= req_last;
                        req_ready <= 1'b0;
                        state     <= ENC;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ENC: begin
                    req_ready <= 1'b0;
                    if (enc_code != ERR_NONE) begin
                        err      <= 1'b1;
                        err_code <= enc_code;
                        state    <= ERROR;
                    end else begin
                        imem_wdata <= enc_word;
                        imem_addr  <= inst_count[ADDR_W-1:0];
                        imem_we    <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    inst_count <= inst_count + CNT_W'(1);
                    if (last_q) begin
                        load_done <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= DONE;
                    end else begin
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DONE: begin
                    req_ready <= 1'b0;
                end
                ERROR: begin
                    req_ready <= 1'b0;
                end
                default: begin
                    req_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader (DEPTH=4): vector table with a write scoreboard
// plus hand sequences for the done-state probe and reset during ENC.
module tb_inst_encoder_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_op = 3'd0;
    logic [4:0]        req_rd = 5'd0;
    logic [4:0]        req_rs1 = 5'd0;
    logic [4:0]        req_rs2 = 5'd0;
    logic [12:0]       req_imm = 13'd0;
    logic              req_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   inst_count;
    logic              load_done;
    logic              err;
    logic [1:0]        err_code;

    inst_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm), .req_last(req_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .inst_count(inst_count), .load_done(load_done),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int unsigned pc = 0;
    always @(posedge clk) pc <= pc + 1;

    typedef struct {
        logic        rst;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
        logic        last;
        logic [1:0]  ecode;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] word;
        int unsigned at;
    } exp_t;

    exp_t sbq[$];
    exp_t e_mon;
    vec_t vt[16];

    int n_cmp  = 0;
    int n_miss = 0;
    int exp_cnt = 0;
    bit exp_err = 0;
    bit exp_done = 0;
    logic [1:0] exp_code = 2'd0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic rst, logic [2:0] op, logic [4:0] rd, logic [4:0] rs1,
                                logic [4:0] rs2, logic [12:0] imm, logic last,
                                logic [1:0] ecode, logic [31:0] word);
        vec_t v;
        v.rst = rst; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.last = last; v.ecode = ecode; v.word = word;
        return v;
    endfunction

    // Scoreboard: every write must match the oldest pending expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_miss++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h want no write",
                         imem_addr, imem_wdata);
            end else begin
                e_mon = sbq.pop_front();
                chk("write_data", imem_wdata, e_mon.word);
                chk("write_addr", 32'(imem_addr), 32'(e_mon.addr));
                chk("write_latency", pc, e_mon.at);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        tick(2);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_count", 32'(inst_count), 32'd0);
        chk("rst_flags", {29'd0, load_done, err_code}, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        exp_cnt = 0; exp_err = 0; exp_done = 0; exp_code = 2'd0;
        sbq.delete();
    endtask

    task automatic send(vec_t v, bit expect_write);
        exp_t e;
        int w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            tick(1);
            w++;
        end
        if (req_ready !== 1'b1) begin
            n_cmp++;
            n_miss++;
            $display("FAIL ready_timeout: got req_ready %b want 1", req_ready);
            return;
        end
        req_op = v.op; req_rd = v.rd; req_rs1 = v.rs1; req_rs2 = v.rs2;
        req_imm = v.imm; req_last = v.last; req_valid = 1'b1;
        if (expect_write) begin
            e.addr = 8'(exp_cnt);
            e.word = v.word;
            e.at   = pc + 2;
            sbq.push_back(e);
        end
        tick(1);
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        //          rst op    rd     rs1    rs2    imm        last ec    word
        vt[0]  = mk(1, 3'd0, 5'd3,  5'd1,  5'd2,  13'h0000, 0, 2'd0, 32'h002081B3);
        vt[1]  = mk(1, 3'd1, 5'd5,  5'd6,  5'd7,  13'h0000, 0, 2'd0, 32'h407302B3);
        vt[2]  = mk(0, 3'd4, 5'd4,  5'd2,  5'd0,  13'h1FFC, 0, 2'd0, 32'hFFC12203);
        vt[3]  = mk(0, 3'd5, 5'd9,  5'd2,  5'd4,  13'h0008, 0, 2'd0, 32'h00412423);
        vt[4]  = mk(0, 3'd3, 5'd31, 5'd0,  5'd31, 13'h0123, 0, 2'd0, 32'h01F06FB3);
        vt[5]  = mk(0, 3'd0, 5'd1,  5'd1,  5'd1,  13'h0000, 0, 2'd3, 32'h0);
        vt[6]  = mk(1, 3'd2, 5'd10, 5'd11, 5'd12, 13'h0000, 0, 2'd0, 32'h00C5F533);
        vt[7]  = mk(0, 3'd4, 5'd1,  5'd1,  5'd0,  13'h07FF, 0, 2'd0, 32'h7FF0A083);
        vt[8]  = mk(0, 3'd5, 5'd0,  5'd6,  5'd5,  13'h1800, 0, 2'd0, 32'h80532023);
        vt[9]  = mk(0, 3'd6, 5'd0,  5'd1,  5'd2,  13'h1FF8, 1, 2'd0, 32'hFE208CE3);
        vt[10] = mk(1, 3'd6, 5'd0,  5'd0,  5'd0,  13'h0004, 0, 2'd0, 32'h00000263);
        vt[11] = mk(0, 3'd7, 5'd1,  5'd2,  5'd3,  13'h0000, 0, 2'd1, 32'h0);
        vt[12] = mk(1, 3'd4, 5'd1,  5'd2,  5'd0,  13'h0800, 0, 2'd2, 32'h0);
        vt[13] = mk(1, 3'd6, 5'd0,  5'd1,  5'd2,  13'h0003, 0, 2'd2, 32'h0);
        vt[14] = mk(1, 3'd7, 5'd0,  5'd0,  5'd0,  13'h0000, 1, 2'd1, 32'h0);
        vt[15] = mk(1, 3'd5, 5'd0,  5'd1,  5'd2,  13'h1000, 0, 2'd2, 32'h0);

        for (int i = 0; i < 16; i++) begin
            if (vt[i].rst) do_reset();
            send(vt[i], vt[i].ecode == 2'd0);
            tick(4);
            if (vt[i].ecode == 2'd0) begin
                exp_cnt++;
                if (vt[i].last) exp_done = 1;
            end else if (!exp_err) begin
                exp_err = 1;
                exp_code = vt[i].ecode;
            end
            chk("count", 32'(inst_count), 32'(exp_cnt));
            chk("err", 32'(err), 32'(exp_err));
            chk("err_code", 32'(err_code), 32'(exp_code));
            chk("load_done", 32'(load_done), 32'(exp_done));
            chk("ready", 32'(req_ready), 32'(!(exp_err || exp_done)));
            if (exp_done) begin
                // Requests offered after completion must be ignored.
                req_op = 3'd0; req_rd = 5'd1; req_rs1 = 5'd1; req_rs2 = 5'd1;
                req_last = 1'b0; req_valid = 1'b1;
                tick(6);
                req_valid = 1'b0;
                chk("done_ready", 32'(req_ready), 32'd0);
                chk("done_count", 32'(inst_count), 32'(exp_cnt));
                chk("done_hold", 32'(load_done), 32'd1);
            end
        end

        // Reset sampled in the ENC cycle aborts the write.
        do_reset();
        send(mk(0, 3'd0, 5'd3, 5'd1, 5'd2, 13'h0, 0, 2'd0, 32'h002081B3), 1'b0);
        reset = 1'b1;
        tick(3);
        chk("abort_we", 32'(imem_we), 32'd0);
        chk("abort_count", 32'(inst_count), 32'd0);
        chk("abort_wdata", imem_wdata, 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        do_reset();
        send(mk(0, 3'd1, 5'd5, 5'd6, 5'd7, 13'h0, 0, 2'd0, 32'h407302B3), 1'b1);
        tick(4);
        chk("abort_next_count", 32'(inst_count), 32'd1);

        tick(2);
        chk("queue_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule

// File: doc/inst_encoder_loader.md
# inst_encoder_loader

Sequential RV32I instruction encoder and instruction-memory loader. It accepts symbolic operations (op, register indices, immediate) over a valid/ready handshake and packs each into a 32-bit instruction word. It writes the words to consecutive instruction-memory word addresses. It is the encode side of the control decoder: it produces exactly the instruction set the core decodes (add, sub, and, or, lw, sw, beq) and sits between the program/debug loader and the instruction memory write port.

## Interface
Parameters:
- ADDR_W, 8: instruction-memory word-address width.
- DEPTH, 256: number of writable words; must satisfy DEPTH ≤ 2^ADDR_W.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: block can accept a request.
- req_op, in, 3: operation code.
  - 0 = add, 1 = sub, 2 = and, 3 = or.
  - 4 = lw, 5 = sw, 6 = beq.
  - 7 = reserved (error).
- req_rd, in, 5: destination register (R-type and lw).
- req_rs1, in, 5: source register 1.
- req_rs2, in, 5: source register 2 (R-type, sw, beq).
- req_imm, in, 13: signed immediate; byte offset for beq.
- req_last, in, 1: this request is the final instruction of the program.
- imem_we, out, 1: instruction-memory write strobe.
- imem_addr, out, ADDR_W: word address.
- imem_wdata, out, 32: encoded instruction.
- inst_count, out, ADDR_W+1: number of words written so far.
- load_done, out, 1: sticky; the last instruction has been written.
- err, out, 1: sticky error flag.
- err_code, out, 2: code of the first error; 1 = bad op, 2 = immediate range, 3 = overflow.

## Operation
- FSM states: IDLE, ENC, WRITE, DONE, ERROR.
- IDLE: req_ready = 1. A request is accepted when req_valid && req_ready. On acceptance, all req_* fields are registered and the FSM moves to ENC.
- ENC: the registered fields are encoded and checked, in this priority order:
  - op = 7 → ERROR, err_code 1.
  - lw/sw with req_imm[12] ≠ req_imm[11] (does not fit signed 12 bits) → ERROR, err_code 2.
  - beq with req_imm[0] = 1 → ERROR, err_code 2.
  - inst_count = DEPTH → ERROR, err_code 3.
  - Otherwise the encoded word is registered into imem_wdata and the FSM moves to WRITE.
- Encoding:
  - R-type: {funct7, rs2, rs1, funct3, rd, 0110011}. funct7 = 0100000 for sub, else 0000000. funct3: add/sub 000, and 111, or 110.
  - lw: {imm[11:0], rs1, 010, rd, 0000011}.
  - sw: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - beq: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}.
  - Fields the instruction format does not use are ignored. Register x0 is encoded as given, with no error.
- WRITE: imem_we = 1 for exactly one cycle, with imem_addr = inst_count[ADDR_W-1:0]. inst_count increments at the end of that cycle. The next state is DONE if the registered req_last is set, else IDLE.
- DONE: req_ready = 0 and load_done = 1 until reset.
- ERROR: req_ready = 0 and err = 1. The erroring request is consumed and not written. err_code holds until reset.
- Addresses never wrap. Writing past DEPTH is always reported as error 3.

## Timing
- Reset values:
  - req_ready = 0 during the reset cycle, 1 from the first cycle after reset deasserts.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - inst_count = 0, load_done = 0, err = 0, err_code = 0.
  - State = IDLE.
- Latency: a request accepted at edge N is written with imem_we high during cycle N+2. Throughput is one instruction per 3 cycles.
- req_ready is a registered state decode and does not depend combinationally on req_valid.
- While req_ready = 0, req_valid is ignored. The requester must hold its request until it is accepted.
- err and load_done assert in the cycle after ENC or WRITE respectively, and are never both set.
- Reset mid-operation (in ENC or WRITE) aborts the pending write: no imem_we is issued after the reset edge. Memory contents already written are untouched.
- A request with req_last = 1 that errors sets err, not load_done.

## Test plan
- add x3,x1,x2 (op 0, rd 3, rs1 1, rs2 2) → one imem_we at addr 0 with wdata 0x002081B3, two cycles after acceptance; inst_count = 1.
- sub x5,x6,x7 then lw x4,-4(x2) (imm 0x1FFC) then sw x4,8(x2) → addresses 0, 1, 2 with wdata 0x407302B3, 0xFFC12203, 0x00412423.
- beq x1,x2,-8 (imm 0x1FF8) with req_last = 1 → wdata 0xFE208CE3. load_done = 1 afterwards, req_ready stays 0, and further req_valid produces no write.
- op 7 → err = 1, err_code = 1, no imem_we. Separately: lw with imm 0x0800 → err_code 2; beq with imm 0x0003 → err_code 2.
- DEPTH = 4: five valid non-last requests → four writes at addresses 0–3, then err_code 3 on the fifth; inst_count = 4.
- Assert reset in the ENC cycle of an accepted request → no imem_we afterwards, all outputs at reset values, and the next request is written to addr 0.
